alu_seq: RTL
============

# alu_seq

Multi-cycle integer execute unit for the RV32I datapath. It consumes the 4-bit `Operation` code produced by the ALU controller, together with the two source operands, through a valid/ready handshake. Shifts are performed iteratively, one bit position per cycle; all other operations complete in one cycle. It returns the result and a `Zero` flag through a second valid/ready handshake to the writeback/branch logic.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width, taken from `SrcB[SHAMT_W-1:0]`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `Operation`  in  4  ALU op code from the ALU controller.
- `SrcA`  in  DATA_WIDTH  first operand.
- `SrcB`  in  DATA_WIDTH  second operand / immediate / shift amount.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `ALUResult`  out  DATA_WIDTH  result.
- `Zero`  out  1  `ALUResult == 0`.

## Operation
Op codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 SUB (A−B), 0100 XOR.
- 0101 SRL, 0110 SLL, 0111 SRA.
- 1000 BEQ compare: result A−B, so `Zero`=1 iff A==B.
- 1010 LUI pass-through: result = SrcB.
- 1110 SLT: signed; result = {0…0, $signed(A)<$signed(B)}.
- Any other code: result 0, `Zero`=1.

Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.

State machine (IDLE, SHIFT, DONE):
- IDLE: `in_ready`=1. On `in_valid`, capture Operation/SrcA/SrcB.
  - Non-shift op: compute, register the result, go to DONE.
  - Shift with shamt=0: result = SrcA, go to DONE.
  - Shift with shamt>0: load the working register with SrcA and the counter with shamt, go to SHIFT.
- SHIFT: each cycle, shift the working register by 1 (SRL fills with 0, SLL fills LSB with 0, SRA replicates the MSB) and decrement the counter. When the counter reaches 1, that cycle's shift is the last one; go to DONE.
- DONE: `out_valid`=1, outputs held stable. On `out_ready`, go to IDLE.

Handshake rules:
- `in_ready` is 1 only in IDLE. Requests presented outside IDLE are not taken; the producer holds them.
- `out_valid` must not drop, and `ALUResult`/`Zero` must not change, until `out_ready` is sampled high.
- Input operands change freely after acceptance; the unit uses only captured copies.

Reset (any state, including mid-shift): state goes to IDLE, the counter and working register clear to 0, the in-flight op is discarded. Output values while `rst_n` is low or immediately after:
- `in_ready`=1, `out_valid`=0, `ALUResult`=0, `Zero`=1.

## Timing
- Request accepted at edge t. Non-shift op: `out_valid` is high in cycle t+1.
- Shift with shamt=k: `out_valid` is high in cycle t+1+k (k=0 gives t+1; k=31 gives t+32).
- Consumption at edge u (`out_valid` & `out_ready`): `in_ready` is high in cycle u+1. There is no same-cycle accept on the completion cycle.
- Peak throughput is one op per 2 cycles. `Zero` is registered together with `ALUResult`.
- `in_ready` and `out_valid` are pure functions of state (Moore); there is no combinational path from input to output.

## Structure
- Shared package `alu_pkg`:
  - enum `alu_op_e` holding the op codes above, reused by the ALU controller.
  - `DATA_WIDTH` and `SHAMT_W` constants.
  - state enum `alu_state_e`.
- Sub-module `alu_shift_step`: a combinational single-bit shifter (SRL/SLL/SRA by 1) instantiated inside SHIFT.
- All single-cycle ops sit in one combinational function in the top module.

## Test plan
- Reset mid-shift: start SLL A=1, B=20; assert `rst_n` low at cycle t+5 → immediately `out_valid`=0, `in_ready`=1, `ALUResult`=0, `Zero`=1. A new ADD accepted after release completes correctly.
- Single-cycle ops:
  - ADD 0x7FFFFFFF+1 → 0x80000000 at t+1.
  - SUB 5−5 → 0, `Zero`=1.
  - BEQ 3,4 → `Zero`=0.
  - SLT −1<1 → 1.
  - LUI B=0x12345000 → 0x12345000.
- Shifts:
  - SRA A=0x80000000, shamt 31 → 0xFFFFFFFF at t+32.
  - SRL same A and shamt → 0x00000001.
  - SLL A=3, shamt 0 → 3 at t+1.
- Output backpressure: ADD 2+3 with `out_ready`=0 for 10 cycles → `out_valid` held high, `ALUResult`=5 stable, `in_ready`=0, and a new `in_valid` is ignored. The new request is accepted the cycle after `out_ready` is taken.
- Back-to-back requests with `in_valid` held high and `out_ready`=1: XOR, OR, AND on A=0xF0F0F0F0, B=0xFF00FF00 → results 0x0FF00FF0, 0xFFF0FFF0, 0xF000F000 at 2-cycle spacing, in order.
- Illegal code 1111 → result 0, `Zero`=1, normal completion at t+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I multi-cycle execute unit and the ALU
// controller that drives it.
//   DATA_WIDTH / SHAMT_W : default operand width and shift-amount width
//   alu_op_e             : 4-bit operation codes issued by the ALU controller
//   alu_state_e          : execute-unit sequencing states
package alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SHAMT_W    = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_LUI = 4'b1010,
    OP_SLT = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shifter used once per cycle while a shift
// is iterating.
//   data_i : current working value
//   op_i   : OP_SRL / OP_SLL / OP_SRA (anything else passes data through)
//   data_o : data_i shifted by one bit position
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle integer execute unit. Single-cycle ops finish one cycle after
// acceptance; shifts iterate one bit per cycle. Request and result each use
// a valid/ready handshake, and both ready/valid outputs decode state only.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : request handshake (ready only in IDLE)
//   Operation, SrcA, SrcB : op code and operands, captured on acceptance
//   out_valid / out_ready : result handshake (valid only in DONE)
//   ALUResult, Zero       : registered result and its zero flag
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for a request, in_ready=1
// ST_SHIFT | iterating a shift, cnt_q shifts remaining
// ST_DONE  | result held, out_valid=1 until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int SHAMT_W    = alu_pkg::SHAMT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  function automatic logic [DATA_WIDTH-1:0] alu_fn(input alu_op_e op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_BEQ:  r = a - b;
      OP_LUI:  r = b;
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  alu_state_e            state_q, state_d;
  alu_op_e               op_q, op_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;

  alu_op_e               op_in;
  logic [SHAMT_W-1:0]    shamt_in;
  logic [DATA_WIDTH-1:0] single_res;
  logic [DATA_WIDTH-1:0] shift_out;

  assign op_in      = alu_op_e'(Operation);
  assign shamt_in   = SrcB[SHAMT_W-1:0];
  assign single_res = alu_fn(op_in, SrcA, SrcB);

  alu_shift_step #(.WIDTH(DATA_WIDTH)) u_shift_step (
    .data_i (work_q),
    .op_i   (op_q),
    .data_o (shift_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift_op(op_in)) begin
            if (shamt_in == '0) begin
              result_d = SrcA;
              zero_d   = (SrcA == '0);
              state_d  = ST_DONE;
            end else begin
              work_d  = SrcA;
              cnt_d   = shamt_in;
              op_d    = op_in;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shift_out;
        cnt_d  = cnt_q - SHAMT_W'(1);
        // Counter at 1 means this cycle performs the final shift.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shift_out;
          zero_d   = (shift_out == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule
